// File: rtl/io_input_port.sv
// Memory-mapped input port: synchronizes and debounces switches/keys, latches key presses,
// and serves single-cycle-latency reads of switches, keys, press latch and a free-running timer.

module io_debounce_bit #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter logic        RST_VAL         = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sync_i,
   output logic db_o,
   output logic db_nxt_o
);
   logic [15:0] cnt_q, cnt_d;
   logic        db_q, db_d;

   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (sync_i == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == 16'(DEBOUNCE_CYCLES - 1)) begin
         db_d  = sync_i;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         db_q  <= RST_VAL;
      end else begin
         cnt_q <= cnt_d;
         db_q  <= db_d;
      end
   end

   assign db_o     = db_q;
   assign db_nxt_o = db_d;
endmodule

module io_input_port #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic        I_CLOCK,
   input  logic        I_LOCK,
   input  logic [9:0]  I_SW,
   input  logic [3:0]  I_KEY,
   input  logic        I_RdReq,
   input  logic [15:0] I_RdAddr,
   output logic        O_RdAck,
   output logic        O_RdHit,
   output logic [15:0] O_RdData,
   output logic        O_KeyPending
);
   localparam int NB = 14;
   // Keys idle high (released), switches idle low.
   localparam logic [NB-1:0] SYNC_RST = {4'hF, 10'h000};

   logic [NB-1:0] raw, sync1_q, sync2_q, db, db_nxt;
   logic [3:0]    latch_q, latch_d, press, clr;
   logic [15:0]   timer_q;
   logic          ack_q, hit_q, hit_c;
   logic [15:0]   data_q, data_c;
   logic          unused_addr;

   assign raw         = {I_KEY, I_SW};
   assign unused_addr = ^I_RdAddr[15:10];

   for (genvar g = 0; g < NB; g++) begin : g_db
      io_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .RST_VAL        (SYNC_RST[g])
      ) u_db (
         .clk_i   (I_CLOCK),
         .rst_ni  (I_LOCK),
         .sync_i  (sync2_q[g]),
         .db_o    (db[g]),
         .db_nxt_o(db_nxt[g])
      );
   end

   // A press is the debounced key falling on this very edge.
   assign press = db[13:10] & ~db_nxt[13:10];

   always_comb begin
      hit_c  = 1'b0;
      data_c = '0;
      clr    = '0;
      if (I_RdReq) begin
         case (I_RdAddr[9:0])
            10'h3F0: begin hit_c = 1'b1; data_c = {6'b0, db[9:0]};      end
            10'h3F1: begin hit_c = 1'b1; data_c = {12'b0, ~db[13:10]};  end
            10'h3F2: begin hit_c = 1'b1; data_c = {12'b0, latch_q}; clr = latch_q; end
            10'h3F3: begin hit_c = 1'b1; data_c = timer_q;              end
            default: ;
         endcase
      end
   end

   // Set wins over read-to-clear.
   assign latch_d = (latch_q & ~clr) | press;

   always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
      if (!I_LOCK) begin
         sync1_q <= SYNC_RST;
         sync2_q <= SYNC_RST;
         latch_q <= '0;
         timer_q <= '0;
         ack_q   <= 1'b0;
         hit_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         latch_q <= latch_d;
         timer_q <= timer_q + 16'd1;
         ack_q   <= I_RdReq;
         hit_q   <= hit_c;
         data_q  <= data_c;
      end
   end

   assign O_RdAck      = ack_q;
   assign O_RdHit      = hit_q;
   assign O_RdData     = data_q;
   assign O_KeyPending = |latch_q;
endmodule

// File: tb/tb_io_input_port.sv
// Scoreboarded bench for io_input_port: reads push expected {hit,data}; a monitor pops on each ack.
module tb_io_input_port;
  logic        I_CLOCK = 1'b0;
  logic        I_LOCK = 1'b0;
  logic [9:0]  I_SW = '0;
  logic [3:0]  I_KEY = 4'hF;
  logic        I_RdReq = 1'b0;
  logic [15:0] I_RdAddr = '0;
  logic        O_RdAck, O_RdHit, O_KeyPending;
  logic [15:0] O_RdData;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  logic [15:0] tmodel = '0;

  io_input_port #(.DEBOUNCE_CYCLES(16)) dut (
    .I_CLOCK(I_CLOCK), .I_LOCK(I_LOCK), .I_SW(I_SW), .I_KEY(I_KEY),
    .I_RdReq(I_RdReq), .I_RdAddr(I_RdAddr), .O_RdAck(O_RdAck),
    .O_RdHit(O_RdHit), .O_RdData(O_RdData), .O_KeyPending(O_KeyPending)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  // Reference timer: counts active (falling) edges since reset release.
  always @(negedge I_CLOCK or negedge I_LOCK)
    if (!I_LOCK) tmodel <= '0;
    else tmodel <= tmodel + 16'd1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(posedge I_CLOCK) begin
    if (O_RdAck) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got hit=%b data=%h expected no ack at %0t", O_RdHit, O_RdData, $time);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("rd_hit", 32'(O_RdHit), 32'(e[16]));
        chk("rd_data", 32'(O_RdData), 32'(e[15:0]));
      end
    end else begin
      chk("idle_zero", 32'({O_RdHit, O_RdData}), 32'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge I_CLOCK);
  endtask

  task automatic rd(input logic [15:0] a, input logic h, input logic [15:0] d);
    I_RdReq  = 1'b1;
    I_RdAddr = a;
    exp_q.push_back({h, d});
    @(posedge I_CLOCK);
  endtask

  task automatic rd_end();
    I_RdReq  = 1'b0;
    I_RdAddr = '0;
  endtask

  initial begin
    // reset state, including a request that must never be acked
    I_RdReq = 1'b1; I_RdAddr = 16'h03F3;
    cyc(3);
    chk("rst_ack", 32'(O_RdAck), 0);
    chk("rst_keypend", 32'(O_KeyPending), 0);
    rd_end();
    cyc(1);
    I_LOCK = 1'b1;
    cyc(2);

    // switches debounce to the static value
    I_SW = 10'h2A5;
    cyc(20);
    rd(16'h03F0, 1'b1, 16'h02A5);
    rd(16'h03F1, 1'b1, 16'h0000);
    rd(16'hA3F0, 1'b1, 16'h02A5);
    rd_end();
    cyc(2);

    // short key glitch is filtered
    I_KEY[1] = 1'b0;
    cyc(5);
    I_KEY[1] = 1'b1;
    cyc(25);
    rd(16'h03F1, 1'b1, 16'h0000);
    rd(16'h03F2, 1'b1, 16'h0000);
    rd_end();
    chk("glitch_keypend", 32'(O_KeyPending), 0);

    // held key latches; read-to-clear
    I_KEY[2] = 1'b0;
    cyc(30);
    chk("hold_keypend", 32'(O_KeyPending), 1);
    rd(16'h03F1, 1'b1, 16'h0004);
    rd(16'h03F2, 1'b1, 16'h0004);
    rd(16'h03F2, 1'b1, 16'h0000);
    rd_end();
    chk("cleared_keypend", 32'(O_KeyPending), 0);
    I_KEY[2] = 1'b1;
    cyc(25);
    rd(16'h03F2, 1'b1, 16'h0000);
    rd_end();

    // press lands on the same edge as a clearing read: set wins
    // 2 sync edges + 16 debounce edges -> press on the 18th falling edge after driving
    I_KEY[0] = 1'b0;
    cyc(17);
    rd(16'h03F2, 1'b1, 16'h0000);
    rd_end();
    cyc(1);
    chk("coincident_keypend", 32'(O_KeyPending), 1);
    rd(16'h03F2, 1'b1, 16'h0001);
    rd(16'h03F2, 1'b1, 16'h0000);
    rd_end();
    I_KEY[0] = 1'b1;
    cyc(25);

    // back-to-back timer reads and an unmapped address
    rd(16'h03F3, 1'b1, tmodel);
    rd(16'h03F3, 1'b1, tmodel);
    rd(16'h0123, 1'b0, 16'h0000);
    rd_end();
    cyc(2);

    // timer wrap
    for (int i = 0; i < 70000 && tmodel != 16'hFFFF; i++) @(posedge I_CLOCK);
    chk("wrap_reached", 32'(tmodel), 32'h0000FFFF);
    rd(16'h03F3, 1'b1, 16'hFFFF);
    rd(16'h03F3, 1'b1, 16'h0000);
    rd_end();
    cyc(2);

    // asynchronous reset with a latched key and a response on the bus
    I_KEY[3] = 1'b0;
    cyc(25);
    chk("pre_rst_keypend", 32'(O_KeyPending), 1);
    I_RdReq = 1'b1; I_RdAddr = 16'h03F2;
    @(negedge I_CLOCK); #1;
    chk("inflight_ack", 32'(O_RdAck), 1);
    chk("inflight_data", 32'(O_RdData), 32'h8);
    I_RdReq = 1'b0; I_KEY = 4'hF; I_LOCK = 1'b0;
    #1;
    chk("async_ack", 32'(O_RdAck), 0);
    chk("async_hit", 32'(O_RdHit), 0);
    chk("async_data", 32'(O_RdData), 0);
    chk("async_keypend", 32'(O_KeyPending), 0);
    cyc(3);
    I_LOCK = 1'b1;
    rd(16'h03F3, 1'b1, 16'h0000);
    rd(16'h03F2, 1'b1, 16'h0000);
    rd_end();
    cyc(5);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
